mask_frame_writer: RTL and testbench

- Producer side of the binary-image path. Consumes the camera luma pixel stream, thresholds each pixel to one bit, and writes it into a ping-pong 1-bit frame buffer (two banks of H_RES*V_RES).
- Publishes each completed frame through a valid/ack handshake. The centroid engine reads the published bank and acks it.
- Also reports the set-pixel count (M00) for each published frame.

---
 rtl/vision_pkg.sv | 17 +
 rtl/pix_coord_counter.sv | 60 ++++++
 rtl/mask_frame_writer.sv | 147 ++++++++++++++
 tb/tb_mask_frame_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vision_pkg.sv
// Shared types and default geometry for the binary-image path
// (mask producer, centroid engine, VGA-side reader).
package vision_pkg;

    localparam int H_RES_C     = 640;
    localparam int V_RES_C     = 480;
    localparam int FRAME_PIX_C = H_RES_C * V_RES_C;

    typedef logic [18:0] addr_t;
    typedef logic [31:0] moment_t;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } fsm_t;

endpackage

// File: rtl/pix_coord_counter.sv
// Raster position tracker: gives the linear address of the pixel being
// presented (SOF forces (0,0)) and flags out-of-range, short and last lines.
module pix_coord_counter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              sof,
    input  logic              eol,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range,
    output logic              short_line,
    output logic              last_line
);

    localparam logic [ADDR_W-1:0] H_L      = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] H_LAST_L = ADDR_W'(H_RES - 1);
    localparam logic [ADDR_W-1:0] V_LAST_L = ADDR_W'(V_RES - 1);

    logic [ADDR_W-1:0] x_r;
    logic [ADDR_W-1:0] y_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] px_x_s;
    logic [ADDR_W-1:0] px_y_s;
    logic [ADDR_W-1:0] px_base_s;

    // Coordinates of the presented pixel; a line base register avoids a multiplier
    always_comb begin
        px_x_s     = sof ? {ADDR_W{1'b0}} : x_r;
        px_y_s     = sof ? {ADDR_W{1'b0}} : y_r;
        px_base_s  = sof ? {ADDR_W{1'b0}} : base_r;
        addr       = px_base_s + px_x_s;
        in_range   = (px_x_s < H_L);
        short_line = eol && (px_x_s < H_LAST_L);
        last_line  = (px_y_s == V_LAST_L);
    end

    // Advance position; x saturates at H_RES so a long line stays out of range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= {ADDR_W{1'b0}};
            y_r    <= {ADDR_W{1'b0}};
            base_r <= {ADDR_W{1'b0}};
        end else if (adv) begin
            if (eol) begin
                x_r    <= {ADDR_W{1'b0}};
                y_r    <= px_y_s + {{(ADDR_W-1){1'b0}}, 1'b1};
                base_r <= px_base_s + H_L;
            end else begin
                x_r    <= in_range ? (px_x_s + {{(ADDR_W-1){1'b0}}, 1'b1}) : px_x_s;
                y_r    <= px_y_s;
                base_r <= px_base_s;
            end
        end
    end

endmodule

// File: rtl/mask_frame_writer.sv
// Thresholds the luma stream into a ping-pong 1-bit frame buffer and
// publishes each completed bank, with its set-pixel count, to the consumer.
module mask_frame_writer
    import vision_pkg::*;
#(
    parameter int H_RES  = H_RES_C,
    parameter int V_RES  = V_RES_C,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_sof,
    input  logic              pix_eol,
    input  logic [PIX_W-1:0]  thresh,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              frame_valid,
    output logic              frame_bank,
    output logic [31:0]       frame_m00,
    input  logic              frame_ack,
    output logic [15:0]       drop_cnt,
    output logic              err_sticky
);

    fsm_t              state_r;
    fsm_t              state_next_s;
    logic [PIX_W-1:0]  thresh_r;
    logic [PIX_W-1:0]  thresh_s;
    moment_t           count_r;
    moment_t           count_next_s;
    logic              cur_bank_r;
    logic              accept_s;
    logic              bit_s;
    logic              wr_s;
    logic              done_s;
    logic              err_s;
    logic              publish_s;
    logic [ADDR_W-1:0] px_addr_s;
    logic              in_range_s;
    logic              short_s;
    logic              last_line_s;

    pix_coord_counter #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W)
    ) u_coord (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .adv        (accept_s),
        .sof        (pix_sof),
        .eol        (pix_eol),
        .addr       (px_addr_s),
        .in_range   (in_range_s),
        .short_line (short_s),
        .last_line  (last_line_s)
    );

    // Pixel acceptance, threshold, completion and next-state decode
    always_comb begin
        accept_s     = pix_valid && (pix_sof || (state_r == ACTIVE));
        thresh_s     = pix_sof ? thresh : thresh_r;
        bit_s        = (pix_data >= thresh_s);
        wr_s         = accept_s && in_range_s;
        count_next_s = (pix_sof ? 32'd0 : count_r) + {31'd0, (wr_s && bit_s)};
        done_s       = accept_s && pix_eol && last_line_s;
        err_s        = accept_s && ((pix_sof && (state_r == ACTIVE)) || !in_range_s || short_s);
        // An ack in the completion cycle frees the slot before the new frame claims it
        publish_s    = done_s && !(frame_valid && !frame_ack);
        state_next_s = state_r;
        if (done_s) begin
            state_next_s = WAIT_SOF;
        end else if (accept_s) begin
            state_next_s = ACTIVE;
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state, latched threshold and running set-pixel count
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r  <= WAIT_SOF;
            thresh_r <= {PIX_W{1'b0}};
            count_r  <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if (accept_s && pix_sof) begin
                thresh_r <= thresh;
            end
            if (accept_s) begin
                count_r <= count_next_s;
            end
        end
    end

    // Frame-buffer write port, one cycle behind the accepted pixel
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_en   <= 1'b0;
            wr_bank <= 1'b0;
            wr_addr <= {ADDR_W{1'b0}};
            wr_data <= 1'b0;
        end else begin
            wr_en   <= wr_s;
            wr_bank <= cur_bank_r;
            if (wr_s) begin
                wr_addr <= px_addr_s;
                wr_data <= bit_s;
            end
        end
    end

    // Publish/drop handshake, bank ping-pong and sticky framing error
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cur_bank_r  <= 1'b0;
            frame_valid <= 1'b0;
            frame_bank  <= 1'b0;
            frame_m00   <= 32'd0;
            drop_cnt    <= 16'd0;
            err_sticky  <= 1'b0;
        end else begin
            if (err_s) begin
                err_sticky <= 1'b1;
            end
            if (publish_s) begin
                frame_valid <= 1'b1;
                frame_bank  <= cur_bank_r;
                frame_m00   <= count_next_s;
                cur_bank_r  <= ~cur_bank_r;
            end else if (done_s) begin
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else if (frame_ack) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mask_frame_writer.sv
// Bench for mask_frame_writer on a 4x3 raster: table-driven clean frame,
// directed handshake/framing/reset sequences and randomized frames vs a model.
module tb_mask_frame_writer;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int PW = 8;
    localparam int AW = 19;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b1;
    logic          pix_valid = 1'b0;
    logic [PW-1:0] pix_data = 8'd0;
    logic          pix_sof = 1'b0;
    logic          pix_eol = 1'b0;
    logic [PW-1:0] thresh = 8'd128;
    logic          frame_ack = 1'b0;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic          frame_valid;
    logic          frame_bank;
    logic [31:0]   frame_m00;
    logic [15:0]   drop_cnt;
    logic          err_sticky;

    mask_frame_writer #(.H_RES(H), .V_RES(V), .PIX_W(PW), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .thresh(thresh), .wr_en(wr_en),
        .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_valid(frame_valid), .frame_bank(frame_bank), .frame_m00(frame_m00),
        .frame_ack(frame_ack), .drop_cnt(drop_cnt), .err_sticky(err_sticky)
    );

    always #5 Clk = ~Clk;

    int n_err = 0;
    int n_chk = 0;

    // Reference model: frame-level view of the raster and the publish slot
    bit       m_active, m_bank, m_fv, m_fb, m_err;
    int       mx, my, m_count, m_m00, m_drop;
    logic [7:0] m_thr;
    bit       e_wr_en, e_wr_data, e_wr_bank;
    int       e_addr;

    typedef struct {
        bit         sof;
        bit         eol;
        logic [7:0] data;
        int         exp_addr;
        bit         exp_data;
        bit         exp_fv;
    } vec_t;
    vec_t tab[H*V];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_bank = 1'b0; m_fv = 1'b0; m_fb = 1'b0; m_err = 1'b0;
        mx = 0; my = 0; m_count = 0; m_m00 = 0; m_drop = 0; m_thr = 8'd0;
        e_wr_en = 1'b0; e_wr_data = 1'b0; e_wr_bank = 1'b0; e_addr = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit s, input bit e,
                              input bit a, input logic [7:0] th);
        bit b;
        e_wr_bank = m_bank;
        e_wr_en   = 1'b0;
        if (a) m_fv = 1'b0;
        if (v && (s || m_active)) begin
            if (s) begin
                if (m_active) m_err = 1'b1;
                m_thr = th; mx = 0; my = 0; m_count = 0; m_active = 1'b1;
            end
            b = (d >= m_thr);
            if (mx < H) begin
                e_wr_en = 1'b1; e_addr = my * H + mx; e_wr_data = b;
                m_count += int'(b);
            end else begin
                m_err = 1'b1;
            end
            if (e) begin
                if (mx < H - 1) m_err = 1'b1;
                if (my == V - 1) begin
                    if (!m_fv) begin
                        m_fv = 1'b1; m_fb = m_bank; m_m00 = m_count; m_bank = !m_bank;
                    end else if (m_drop < 65535) begin
                        m_drop++;
                    end
                    m_active = 1'b0;
                end else begin
                    mx = 0; my++;
                end
            end else begin
                mx++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("wr_en", {31'd0, wr_en}, {31'd0, e_wr_en});
        if (e_wr_en) begin
            chk("wr_addr", {13'd0, wr_addr}, 32'(e_addr));
            chk("wr_data", {31'd0, wr_data}, {31'd0, e_wr_data});
        end
        chk("wr_bank", {31'd0, wr_bank}, {31'd0, e_wr_bank});
        chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
        chk("frame_bank", {31'd0, frame_bank}, {31'd0, m_fb});
        chk("frame_m00", frame_m00, 32'(m_m00));
        chk("drop_cnt", {16'd0, drop_cnt}, 32'(m_drop));
        chk("err_sticky", {31'd0, err_sticky}, {31'd0, m_err});
    endtask

    // One clock: apply inputs, clock, then compare against the model
    task automatic drive(input bit v, input logic [7:0] d, input bit s, input bit e, input bit a);
        pix_valid = v; pix_data = d; pix_sof = s; pix_eol = e; frame_ack = a;
        @(posedge Clk);
        #1;
        model_step(v, d, s, e, a, thresh);
        check_outputs();
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0; frame_ack = 1'b0;
    endtask

    task automatic send_pixels(input int first, input int last, input int pat, input bit ack_last);
        logic [7:0] d;
        for (int i = first; i <= last; i++) begin
            if (pat == 0)      d = (i % 2 == 1) ? 8'd50 : 8'd200;
            else if (pat == 1) d = 8'd255;
            else               d = 8'($urandom_range(0, 255));
            drive(1'b1, d, i == 0, (i % H) == H - 1, ack_last && (i == last));
        end
    endtask

    // Asynchronous reset pulse placed mid-cycle
    task automatic do_reset();
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {13'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {31'd0, wr_data}, 32'd0);
        chk("rst_wr_bank", {31'd0, wr_bank}, 32'd0);
        chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_frame_bank", {31'd0, frame_bank}, 32'd0);
        chk("rst_frame_m00", frame_m00, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
        model_reset();
        #4;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int i = 0; i < H * V; i++) begin
            tab[i].sof      = (i == 0);
            tab[i].eol      = ((i % H) == H - 1);
            tab[i].data     = (i % 2 == 1) ? 8'd50 : 8'd200;
            tab[i].exp_addr = i;
            tab[i].exp_data = (i % 2 == 0);
            tab[i].exp_fv   = (i == H * V - 1);
        end

        @(posedge Clk);
        #1;
        do_reset();
        drive(1'b1, 8'd200, 1'b0, 1'b0, 1'b0);
        chk("wait_sof_ignore", {31'd0, wr_en}, 32'd0);

        // Clean frame from the table
        thresh = 8'd128;
        for (int i = 0; i < H * V; i++) begin
            drive(1'b1, tab[i].data, tab[i].sof, tab[i].eol, 1'b0);
            chk("tab_wr_en", {31'd0, wr_en}, 32'd1);
            chk("tab_wr_addr", {13'd0, wr_addr}, 32'(tab[i].exp_addr));
            chk("tab_wr_data", {31'd0, wr_data}, {31'd0, tab[i].exp_data});
            chk("tab_frame_valid", {31'd0, frame_valid}, {31'd0, tab[i].exp_fv});
        end
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("f1_bank", {31'd0, frame_bank}, 32'd0);
        chk("f1_m00", frame_m00, 32'd6);
        chk("f1_wr_bank_after", {31'd0, wr_bank}, 32'd1);

        // Second frame without ack is dropped; third after ack publishes bank 1
        send_pixels(0, H * V - 1, 0, 1'b0);
        chk("drop_one", {16'd0, drop_cnt}, 32'd1);
        chk("drop_fv_held", {31'd0, frame_valid}, 32'd1);
        chk("drop_bank_held", {31'd0, frame_bank}, 32'd0);
        chk("drop_m00_held", frame_m00, 32'd6);
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("ack_clears", {31'd0, frame_valid}, 32'd0);
        send_pixels(0, H * V - 1, 1, 1'b0);
        chk("f3_bank", {31'd0, frame_bank}, 32'd1);
        chk("f3_m00", frame_m00, 32'd12);

        // Ack coinciding with completion: no drop, new frame publishes
        send_pixels(0, H * V - 1, 0, 1'b1);
        chk("ackcomp_fv", {31'd0, frame_valid}, 32'd1);
        chk("ackcomp_bank", {31'd0, frame_bank}, 32'd0);
        chk("ackcomp_drop", {16'd0, drop_cnt}, 32'd1);

        // Reset mid-frame, then stray pixels, then a clean frame in bank 0
        send_pixels(0, 4, 1, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'd255, 1'b0, i == 3, 1'b0);
            chk("post_rst_ignore", {31'd0, wr_en}, 32'd0);
        end
        send_pixels(0, H * V - 1, 0, 1'b0);
        chk("post_rst_bank", {31'd0, frame_bank}, 32'd0);
        chk("post_rst_fv", {31'd0, frame_valid}, 32'd1);

        // SOF at (1,2) restarts the frame
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        send_pixels(0, 2 * H, 1, 1'b0);
        drive(1'b1, 8'd255, 1'b1, 1'b0, 1'b0);
        chk("restart_err", {31'd0, err_sticky}, 32'd1);
        chk("restart_addr", {13'd0, wr_addr}, 32'd0);
        send_pixels(1, H * V - 1, 1, 1'b0);
        chk("restart_m00", frame_m00, 32'd12);
        chk("restart_bank", {31'd0, frame_bank}, 32'd1);

        // Short line then long line
        do_reset();
        drive(1'b1, 8'd255, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'd255, 1'b0, 1'b1, 1'b0);
        chk("short_err", {31'd0, err_sticky}, 32'd1);
        drive(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        chk("line1_addr", {13'd0, wr_addr}, 32'd4);
        for (int i = 1; i < 4; i++) drive(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'd255, 1'b0, 1'b1, 1'b0);
        chk("long_no_write", {31'd0, wr_en}, 32'd0);
        drive(1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
        chk("line2_addr", {13'd0, wr_addr}, 32'd8);
        for (int i = 1; i < 4; i++) drive(1'b1, 8'd255, 1'b0, i == 3, 1'b0);
        chk("shortlong_fv", {31'd0, frame_valid}, 32'd1);
        chk("shortlong_m00", frame_m00, 32'd10);

        // Randomized frames with gaps, stray flags and random acks
        for (int f = 0; f < 10; f++) begin
            thresh = 8'($urandom_range(0, 255));
            for (int i = 0; i < H * V; i++) begin
                while ($urandom_range(0, 3) == 0)
                    drive(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
                drive(1'b1, 8'($urandom_range(0, 255)), i == 0, (i % H) == H - 1,
                      $urandom_range(0, 3) == 0);
            end
        end
        drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
